// File: rtl/regfile_sb_if.sv
// Bus interface for regfile_sb: write, lock and dual read ports.
// master drives the requests, slave is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              w;
  logic [ADDR_W-1:0] sw;
  logic [DATA_W-1:0] c_in;
  logic [ADDR_W-1:0] sa;
  logic [ADDR_W-1:0] sb;
  logic              lock;
  logic [ADDR_W-1:0] sl;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              a_busy;
  logic              b_busy;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output w, sw, c_in, sa, sb, lock, sl,
    input  a_out, b_out, a_busy, b_busy, busy_cnt
  );

  modport slave (
    input  w, sw, c_in, sa, sb, lock, sl,
    output a_out, b_out, a_busy, b_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with registered, write-bypassed read ports
// and a per-register busy scoreboard for multi-cycle producers.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero and
// keeps it permanently non-busy.
module regfile_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic              w_eff;
  logic              lock_eff;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Effective write/lock, next busy vector, counter steps and bypassed read data.
  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    w_eff    = bus.w && (bus.sw != '0);
    lock_eff = bus.lock && (bus.sl != '0);
`else
    w_eff    = bus.w;
    lock_eff = bus.lock;
`endif
    busy_next = busy;
    if (w_eff)    busy_next[bus.sw] = 1'b0;
    if (lock_eff) busy_next[bus.sl] = 1'b1;

    // A lock on the written register keeps the bit set, so no decrement then.
    cnt_inc = lock_eff && !busy[bus.sl];
    cnt_dec = w_eff && busy[bus.sw] && !(lock_eff && (bus.sl == bus.sw));

    rd_a = (w_eff && (bus.sw == bus.sa)) ? bus.c_in : regs[bus.sa];
    rd_b = (w_eff && (bus.sw == bus.sb)) ? bus.c_in : regs[bus.sb];
`ifdef REGFILE_ZERO_REG_EN
    if (bus.sa == '0) rd_a = '0;
    if (bus.sb == '0) rd_b = '0;
`endif
  end

  // State update: registers, scoreboard, counter and registered read ports.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy         <= '0;
      bus.a_out    <= '0;
      bus.b_out    <= '0;
      bus.a_busy   <= 1'b0;
      bus.b_busy   <= 1'b0;
      bus.busy_cnt <= '0;
    end else begin
      if (w_eff) regs[bus.sw] <= bus.c_in;
      busy       <= busy_next;
      bus.a_out  <= rd_a;
      bus.b_out  <= rd_b;
      bus.a_busy <= busy_next[bus.sa];
      bus.b_busy <= busy_next[bus.sb];
      if (cnt_inc && !cnt_dec)
        bus.busy_cnt <= bus.busy_cnt + CNT_W'(1);
      else if (cnt_dec && !cnt_inc)
        bus.busy_cnt <= bus.busy_cnt - CNT_W'(1);
    end
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the processor's 8x8 register file, for the pipelined DAPA core.
- Adds configurable data width and depth, and registered read ports with 1-cycle latency.
- Read ports have write-to-read bypass.
- A per-register scoreboard (busy bits) tracks multi-cycle producers such as loads and multiply; decode stage uses it to stall on RAW hazards.

Parameters:
- DATA_W, 8, data width of each register and of the c_in/a_out/b_out buses
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W registers

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk
- w  input  1  write enable
- sw  input  ADDR_W  write address
- c_in  input  DATA_W  write data
- sa  input  ADDR_W  read address, port A
- sb  input  ADDR_W  read address, port B
- lock  input  1  mark register sl busy (pending producer issued)
- sl  input  ADDR_W  lock address
- a_out  output  DATA_W  registered read data, port A
- b_out  output  DATA_W  registered read data, port B
- a_busy  output  1  registered busy flag of register read on port A
- b_busy  output  1  registered busy flag of register read on port B
- busy_cnt  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (reset=0 at edge):
  - all registers, busy bits, a_out, b_out, a_busy, b_busy and busy_cnt go to 0.
  - w and lock are ignored that cycle.
  - Reset mid-operation discards all pending locks.
- Write: at edge with w=1, reg[sw] <= c_in, and busy[sw] is cleared (producer completed).
- Lock: at edge with lock=1, busy[sl] <= 1.
- Simultaneous write and lock, same address: register takes c_in, and busy ends 1 (lock wins; a new producer was issued).
- Locking an already-busy register: busy stays 1; busy_cnt does not change.
- Write to a non-busy register: busy stays 0; busy_cnt does not change.
- Read, latency 1: at every edge (not in reset):
  - a_out <= (w && sw==sa) ? c_in : reg[sa]; b_out likewise with sb.
  - Bypass is write-first; both ports may bypass the same write.
- Busy flags: a_busy <= busy_next[sa], b_busy <= busy_next[sb].
  - busy_next is the busy vector after this edge's write-clear and lock-set.
  - The flag is therefore consistent with the data presented.
- busy_cnt: registered popcount of busy_next, range 0..NREGS. Updated as an incremental +1/-1/0 counter, not a full popcount.
  - +1 when lock sets a 0 bit.
  - -1 when a write clears a 1 bit and no lock targets the same register.
  - Both +1 and -1 on different addresses gives net 0.
- No default/illegal address cases: all ADDR_W encodings are valid.
- Read ports are pure functions of inputs and state; no enable. Outputs update every cycle.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to zero; writes to address 0 are discarded.
  - lock to address 0 is ignored (busy[0] is always 0 and never counted).
  - reads of address 0 return 0 with busy flag 0, including when w=1, sw=0 (no bypass).
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset then read: hold reset=0 two cycles, release; sa=5, sb=7 -> next cycle a_out=0x00, b_out=0x00, a_busy=b_busy=0, busy_cnt=0.
- Write/read latency: w=1, sw=3, c_in=0xA5 at edge N; sa=3 at edge N+1 -> a_out=0xA5 after N+1. Also sa=3 at edge N -> a_out=0xA5 after N (bypass). sb=2 at N -> b_out=0x00.
- Scoreboard: lock sl=4 at N, then lock sl=6 at N+1 -> busy_cnt=1 then 2. Then w=1, sw=4, c_in=0x3C with sa=4 -> a_out=0x3C, a_busy=0, busy_cnt=1.
- Simultaneous write+lock on the same register: lock=1, sl=2, w=1, sw=2, c_in=0x11, sa=2 -> a_out=0x11, a_busy=1, busy_cnt increments by 1.
- Mid-operation reset: lock three registers (busy_cnt=3), assert reset=0 one edge -> busy_cnt=0, all reads 0x00 with busy 0.
- REGFILE_ZERO_REG_EN defined: w=1, sw=0, c_in=0xFF, lock=1, sl=0, sa=0 -> a_out=0x00, a_busy=0, busy_cnt unchanged. Same stimulus without the macro -> a_out=0xFF, a_busy=1.
